// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter shared by instruction fetch and data
// load/store. One transfer is outstanding at a time; data requests win over
// fetches. A transfer that sees no i_ramReady for MAX_WAIT busy cycles is
// aborted with an o_error pulse, and the still-held request is retried.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_ifReq/i_ifAddr              fetch request and address
//   o_ifInst/o_ifValid            fetched word and one-cycle completion pulse
//   i_memReadEnable/WriteEnable   load/store request (store wins if both)
//   i_memAddr/i_memSel/i_memWData data address, byte lanes, store data
//   o_memRData/o_memValid         load data and one-cycle completion pulse
//   o_ramEnable/o_ramWrite/o_ramAddr/o_ramSel/o_ramWData  RAM request
//   i_ramRData/i_ramReady         RAM read data and completion strobe
//   o_stallReq                    combinational pipeline stall
//   o_error                       one-cycle timeout pulse
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ifReq,
  input  logic [ADDR_WIDTH-1:0] i_ifAddr,
  output logic [DATA_WIDTH-1:0] o_ifInst,
  output logic                  o_ifValid,
  input  logic                  i_memReadEnable,
  input  logic                  i_memWriteEnable,
  input  logic [ADDR_WIDTH-1:0] i_memAddr,
  input  logic [3:0]            i_memSel,
  input  logic [DATA_WIDTH-1:0] i_memWData,
  output logic [DATA_WIDTH-1:0] o_memRData,
  output logic                  o_memValid,
  output logic                  o_ramEnable,
  output logic                  o_ramWrite,
  output logic [ADDR_WIDTH-1:0] o_ramAddr,
  output logic [3:0]            o_ramSel,
  output logic [DATA_WIDTH-1:0] o_ramWData,
  input  logic [DATA_WIDTH-1:0] i_ramRData,
  input  logic                  i_ramReady,
  output logic                  o_stallReq,
  output logic                  o_error
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ram_enable_q, ram_enable_d;
  logic                  ram_write_q, ram_write_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]            ram_sel_q, ram_sel_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  error_q, error_d;

  // A requester is not served again while its valid pulse is out: it is
  // still holding the request it just had completed.
  logic data_pend, if_pend;
  assign data_pend = (i_memReadEnable | i_memWriteEnable) & ~mem_valid_q;
  assign if_pend   = i_ifReq & ~if_valid_q;

  assign o_stallReq = data_pend | if_pend;

  // Next-state, grant, completion and timeout logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ram_enable_d = ram_enable_q;
    ram_write_d  = ram_write_q;
    ram_addr_d   = ram_addr_q;
    ram_sel_d    = ram_sel_q;
    ram_wdata_d  = ram_wdata_q;
    if_inst_d    = if_inst_q;
    mem_rdata_d  = mem_rdata_q;
    if_valid_d   = 1'b0;
    mem_valid_d  = 1'b0;
    error_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_pend) begin
          state_d      = S_DATA;
          cnt_d        = '0;
          ram_enable_d = 1'b1;
          ram_write_d  = i_memWriteEnable;
          ram_addr_d   = i_memAddr;
          ram_sel_d    = i_memSel;
          ram_wdata_d  = i_memWriteEnable ? i_memWData : '0;
        end else if (if_pend) begin
          state_d      = S_INST;
          cnt_d        = '0;
          ram_enable_d = 1'b1;
          ram_write_d  = 1'b0;
          ram_addr_d   = i_ifAddr;
          ram_sel_d    = 4'b1111;
          ram_wdata_d  = '0;
        end
      end
      S_DATA, S_INST: begin
        if (i_ramReady) begin
          if (state_q == S_DATA) begin
            mem_rdata_d = i_ramRData;
            mem_valid_d = 1'b1;
          end else begin
            if_inst_d  = i_ramRData;
            if_valid_d = 1'b1;
          end
          ram_enable_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          // This busy cycle is the MAX_WAIT-th without ready: abort.
          ram_enable_d = 1'b0;
          error_d      = 1'b1;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ram_enable_q <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_sel_q    <= '0;
      ram_wdata_q  <= '0;
      if_inst_q    <= '0;
      mem_rdata_q  <= '0;
      if_valid_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ram_enable_q <= ram_enable_d;
      ram_write_q  <= ram_write_d;
      ram_addr_q   <= ram_addr_d;
      ram_sel_q    <= ram_sel_d;
      ram_wdata_q  <= ram_wdata_d;
      if_inst_q    <= if_inst_d;
      mem_rdata_q  <= mem_rdata_d;
      if_valid_q   <= if_valid_d;
      mem_valid_q  <= mem_valid_d;
      error_q      <= error_d;
    end
  end

  assign o_ramEnable = ram_enable_q;
  assign o_ramWrite  = ram_write_q;
  assign o_ramAddr   = ram_addr_q;
  assign o_ramSel    = ram_sel_q;
  assign o_ramWData  = ram_wdata_q;
  assign o_ifInst    = if_inst_q;
  assign o_memRData  = mem_rdata_q;
  assign o_ifValid   = if_valid_q;
  assign o_memValid  = mem_valid_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM responder with programmable wait states,
// requesters that drop their request on the valid pulse, and scoreboards of
// expected read data checked whenever a valid pulse appears.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 15;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic          clk, rst;
  logic          i_ifReq;
  logic [AW-1:0] i_ifAddr;
  logic [DW-1:0] o_ifInst;
  logic          o_ifValid;
  logic          i_memReadEnable, i_memWriteEnable;
  logic [AW-1:0] i_memAddr;
  logic [3:0]    i_memSel;
  logic [DW-1:0] i_memWData;
  logic [DW-1:0] o_memRData;
  logic          o_memValid;
  logic          o_ramEnable, o_ramWrite;
  logic [AW-1:0] o_ramAddr;
  logic [3:0]    o_ramSel;
  logic [DW-1:0] o_ramWData;
  logic [DW-1:0] i_ramRData;
  logic          i_ramReady;
  logic          o_stallReq;
  logic          o_error;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_ifReq(i_ifReq), .i_ifAddr(i_ifAddr), .o_ifInst(o_ifInst), .o_ifValid(o_ifValid),
    .i_memReadEnable(i_memReadEnable), .i_memWriteEnable(i_memWriteEnable),
    .i_memAddr(i_memAddr), .i_memSel(i_memSel), .i_memWData(i_memWData),
    .o_memRData(o_memRData), .o_memValid(o_memValid),
    .o_ramEnable(o_ramEnable), .o_ramWrite(o_ramWrite), .o_ramAddr(o_ramAddr),
    .o_ramSel(o_ramSel), .o_ramWData(o_ramWData),
    .i_ramRData(i_ramRData), .i_ramReady(i_ramReady),
    .o_stallReq(o_stallReq), .o_error(o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total, bad;
  int          if_seen, mem_seen, err_seen;
  int          busy, wait_cycles;
  logic        ram_hang, force_ready, stall_s;
  logic [31:0] if_q[$];
  exp_t        mem_q[$];
  logic [31:0] ram_mem [256];

  // One clock: sample outputs at the falling edge, score valid pulses,
  // let requesters drop on valid, then drive the RAM responder.
  task automatic cycle();
    exp_t        e;
    logic [31:0] ei;
    logic [7:0]  idx;
    @(negedge clk);
    stall_s = o_stallReq;
    if (o_ifValid === 1'b1) begin
      if_seen++;
      total++;
      if (if_q.size() == 0) begin
        bad++;
        $display("FAIL if_scoreboard: unexpected o_ifValid inst=%h", o_ifInst);
      end else begin
        ei = if_q.pop_front();
        if (o_ifInst !== ei) begin
          bad++;
          $display("FAIL if_inst: got %h expected %h", o_ifInst, ei);
        end
      end
      i_ifReq = 1'b0;
    end
    if (o_memValid === 1'b1) begin
      mem_seen++;
      total++;
      if (mem_q.size() == 0) begin
        bad++;
        $display("FAIL mem_scoreboard: unexpected o_memValid rdata=%h", o_memRData);
      end else begin
        e = mem_q.pop_front();
        if (e.chk && o_memRData !== e.data) begin
          bad++;
          $display("FAIL mem_rdata: got %h expected %h", o_memRData, e.data);
        end
      end
      i_memReadEnable  = 1'b0;
      i_memWriteEnable = 1'b0;
    end
    if (o_error === 1'b1) err_seen++;
    if (o_ramEnable === 1'b1) busy++;
    else busy = 0;
    idx        = o_ramAddr[9:2];
    i_ramRData = ram_mem[idx];
    i_ramReady = force_ready | ((o_ramEnable === 1'b1) && !ram_hang && (busy > wait_cycles));
    if (i_ramReady && o_ramEnable === 1'b1 && o_ramWrite === 1'b1)
      for (int b = 0; b < 4; b++)
        if (o_ramSel[b]) ram_mem[idx][8*b +: 8] = o_ramWData[8*b +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    total++;
    if ({o_ramEnable, o_ramWrite, o_ramAddr, o_ramSel, o_ramWData, o_ifInst, o_memRData,
         o_ifValid, o_memValid, o_error} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b wr=%b addr=%h sel=%h wd=%h inst=%h rd=%h v=%b%b err=%b expected all 0",
               o_ramEnable, o_ramWrite, o_ramAddr, o_ramSel, o_ramWData, o_ifInst, o_memRData,
               o_ifValid, o_memValid, o_error);
    end
    rst = 1'b0;
    cycle();
    total++;
    if (stall_s !== 1'b0 || o_ramEnable !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: stall=%b en=%b expected 0 0", stall_s, o_ramEnable);
    end
  endtask

  task automatic test_fetch_zero_wait();
    ram_mem[4]  = 32'h3C01_0001;
    force_ready = 1'b1;
    i_ifAddr    = 32'h10;
    i_ifReq     = 1'b1;
    if_q.push_back(32'h3C01_0001);
    cycle();
    total++;
    if ({o_ramEnable, o_ramWrite, o_ramAddr, o_ramSel, o_ramWData} !== {1'b1, 1'b0, 32'h10, 4'hF, 32'h0}) begin
      bad++;
      $display("FAIL fetch_grant: en=%b wr=%b addr=%h sel=%h wd=%h expected 1 0 00000010 f 00000000",
               o_ramEnable, o_ramWrite, o_ramAddr, o_ramSel, o_ramWData);
    end
    total++;
    if (stall_s !== 1'b1) begin
      bad++;
      $display("FAIL fetch_stall: got %b expected 1", stall_s);
    end
    cycle();
    total++;
    if (o_ifValid !== 1'b1) begin
      bad++;
      $display("FAIL fetch_latency: o_ifValid=%b expected 1 two cycles after request", o_ifValid);
    end
    total++;
    if (o_ramEnable !== 1'b0) begin
      bad++;
      $display("FAIL fetch_enable_one_cycle: o_ramEnable=%b expected 0", o_ramEnable);
    end
    cycle();
    total++;
    if (o_ifValid !== 1'b0 || o_ifInst !== 32'h3C01_0001) begin
      bad++;
      $display("FAIL fetch_hold: valid=%b inst=%h expected 0 3c010001", o_ifValid, o_ifInst);
    end
    total++;
    if (o_ramEnable !== 1'b0) begin
      bad++;
      $display("FAIL fetch_no_regrant: o_ramEnable=%b expected 0", o_ramEnable);
    end
    force_ready = 1'b0;
  endtask

  task automatic test_contention();
    int   mem_at, if_at;
    logic stall_ok;
    ram_mem[8]      = 32'h1111_2222;
    ram_mem[12]     = 32'h3333_4444;
    wait_cycles     = 0;
    i_memAddr       = 32'h20;
    i_memSel        = 4'hF;
    i_memReadEnable = 1'b1;
    i_ifAddr        = 32'h30;
    i_ifReq         = 1'b1;
    mem_q.push_back({1'b1, 32'h1111_2222});
    if_q.push_back(32'h3333_4444);
    mem_at   = -1;
    if_at    = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 20 && if_at < 0; c++) begin
      cycle();
      if (o_memValid === 1'b1 && mem_at < 0) mem_at = c;
      if (o_ifValid === 1'b1) if_at = c;
      else if (stall_s !== 1'b1) stall_ok = 1'b0;
    end
    total++;
    if (mem_at != 2) begin
      bad++;
      $display("FAIL contention_data_first: o_memValid at cycle %0d expected 2", mem_at);
    end
    total++;
    if (if_at != 4) begin
      bad++;
      $display("FAIL contention_fetch_next: o_ifValid at cycle %0d expected 4", if_at);
    end
    total++;
    if (stall_ok !== 1'b1) begin
      bad++;
      $display("FAIL contention_stall: stall dropped before o_ifValid got %b expected 1", stall_ok);
    end
  endtask

  task automatic test_store_wait();
    int   busy_n, pulses;
    logic stable_ok;
    cycle();
    wait_cycles      = 3;
    mem_q.push_back({1'b1, ram_mem[8]});
    i_memAddr        = 32'h20;
    i_memSel         = 4'b0011;
    i_memWData       = 32'hDEAD_BEEF;
    i_memWriteEnable = 1'b1;
    i_memReadEnable  = 1'b1;
    busy_n    = 0;
    pulses    = 0;
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (o_ramEnable === 1'b1) begin
        busy_n++;
        if ({o_ramWrite, o_ramAddr, o_ramSel, o_ramWData} !== {1'b1, 32'h20, 4'b0011, 32'hDEAD_BEEF})
          stable_ok = 1'b0;
      end
      if (o_memValid === 1'b1) pulses++;
    end
    total++;
    if (busy_n != 4) begin
      bad++;
      $display("FAIL store_busy_cycles: got %0d expected 4", busy_n);
    end
    total++;
    if (stable_ok !== 1'b1) begin
      bad++;
      $display("FAIL store_ram_stable: got %b expected 1", stable_ok);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL store_valid_pulses: got %0d expected 1", pulses);
    end
    total++;
    if (ram_mem[8] !== 32'h1111_BEEF) begin
      bad++;
      $display("FAIL store_ram_word: got %h expected 1111beef", ram_mem[8]);
    end
  endtask

  task automatic test_timeout();
    int   busy_n, err_busy, err0, if0;
    logic valid_in_err;
    cycle();
    ram_hang    = 1'b1;
    wait_cycles = 0;
    i_ifAddr    = 32'h30;
    i_ifReq     = 1'b1;
    if_q.push_back(32'h3333_4444);
    err0         = err_seen;
    if0          = if_seen;
    busy_n       = 0;
    err_busy     = -1;
    valid_in_err = 1'b0;
    for (int c = 0; c < 40 && err_busy < 0; c++) begin
      cycle();
      if (o_ramEnable === 1'b1) busy_n++;
      if (o_error === 1'b1) begin
        err_busy     = busy_n;
        valid_in_err = o_ifValid | o_memValid;
      end
    end
    ram_hang = 1'b0;
    total++;
    if (err_busy != 15) begin
      bad++;
      $display("FAIL timeout_busy_cycles: error after %0d busy cycles expected 15", err_busy);
    end
    total++;
    if (valid_in_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_no_valid: got %b expected 0", valid_in_err);
    end
    cycle();
    total++;
    if (o_error !== 1'b0 || o_ramEnable !== 1'b1) begin
      bad++;
      $display("FAIL timeout_retry_grant: err=%b en=%b expected 0 1", o_error, o_ramEnable);
    end
    for (int c = 0; c < 10 && if_seen == if0; c++) cycle();
    total++;
    if (if_seen != if0 + 1 || err_seen != err0 + 1) begin
      bad++;
      $display("FAIL timeout_retry_done: fetches=%0d errors=%0d expected 1 1",
               if_seen - if0, err_seen - err0);
    end
  endtask

  task automatic test_reset_mid();
    int   seen0;
    logic activity;
    cycle();
    wait_cycles = 5;
    i_ifAddr    = 32'h10;
    i_ifReq     = 1'b1;
    cycle();
    cycle();
    total++;
    if (o_ramEnable !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_busy: o_ramEnable=%b expected 1", o_ramEnable);
    end
    rst     = 1'b1;
    i_ifReq = 1'b0;
    cycle();
    total++;
    if ({o_ramEnable, o_ramWrite, o_ramAddr, o_ramSel, o_ramWData, o_ifInst, o_memRData,
         o_ifValid, o_memValid, o_error} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: en=%b addr=%h inst=%h rd=%h v=%b%b err=%b expected all 0",
               o_ramEnable, o_ramAddr, o_ifInst, o_memRData, o_ifValid, o_memValid, o_error);
    end
    rst         = 1'b0;
    force_ready = 1'b1;
    seen0       = if_seen + mem_seen + err_seen;
    activity    = 1'b0;
    repeat (6) begin
      cycle();
      if (o_ramEnable !== 1'b0 || o_ifValid !== 1'b0 || o_memValid !== 1'b0 || o_error !== 1'b0)
        activity = 1'b1;
    end
    force_ready = 1'b0;
    total++;
    if (activity !== 1'b0 || if_seen + mem_seen + err_seen != seen0) begin
      bad++;
      $display("FAIL reset_mid_idle: activity=%b events=%0d expected 0 0",
               activity, if_seen + mem_seen + err_seen - seen0);
    end
  endtask

  initial begin
    total = 0; bad = 0; if_seen = 0; mem_seen = 0; err_seen = 0;
    busy = 0; wait_cycles = 0; ram_hang = 1'b0; force_ready = 1'b0; stall_s = 1'b0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
    rst = 1'b1;
    i_ifReq = 1'b0; i_ifAddr = '0;
    i_memReadEnable = 1'b0; i_memWriteEnable = 1'b0;
    i_memAddr = '0; i_memSel = '0; i_memWData = '0;
    i_ramRData = '0; i_ramReady = 1'b0;

    test_reset();
    test_fetch_zero_wait();
    test_contention();
    test_store_wait();
    test_timeout();
    test_reset_mid();

    total++;
    if (if_q.size() != 0 || mem_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending if=%0d mem=%0d expected 0 0", if_q.size(), mem_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
